// File: rtl/polyphase_output_commutator_pkg.sv
// Shared constants and types for the Tx polyphase interpolator output stage.
// The branch widths here are also used by the E0..E3 comb branches.
package polyphase_commutator_pkg;

  localparam int PHASES = 4;
  localparam int IN_W   = 20;
  localparam int OUT_W  = 11;
  localparam int SHIFT  = 9;

  typedef logic [$clog2(PHASES)-1:0] phase_t;

  localparam phase_t LAST_PHASE = phase_t'(PHASES - 1);

endpackage

// File: rtl/polyphase_output_commutator_if.sv
// Branch-input / serialised-output bundle of the polyphase output commutator.
interface polyphase_output_commutator_if;
  import polyphase_commutator_pkg::*;

  logic                    in_valid;
  logic signed [IN_W-1:0]  in_e0;
  logic signed [IN_W-1:0]  in_e1;
  logic signed [IN_W-1:0]  in_e2;
  logic signed [IN_W-1:0]  in_e3;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  phase_t                  out_phase;
  logic                    overrun;

  modport master (
    output in_valid, in_e0, in_e1, in_e2, in_e3,
    input  out_data, out_valid, out_phase, overrun
  );

  modport slave (
    input  in_valid, in_e0, in_e1, in_e2, in_e3,
    output out_data, out_valid, out_phase, overrun
  );

endinterface

// File: rtl/round_sat.sv
// Combinational round-half-up rescale by 2^SHIFT with saturation to OUT_W bits.
// Shared with the Rx decimator output.
module round_sat #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 11,
  parameter int SHIFT = 9
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y
);

  localparam int MAX_I = (2 ** (OUT_W - 1)) - 1;
  localparam int MIN_I = -(2 ** (OUT_W - 1));
  localparam logic signed [IN_W:0] MAX_V = (IN_W + 1)'(MAX_I);
  localparam logic signed [IN_W:0] MIN_V = (IN_W + 1)'(MIN_I);
  localparam logic signed [IN_W:0] HALF  = (IN_W + 1)'(2 ** (SHIFT - 1));

  // One guard bit keeps the rounding offset add from wrapping.
  function automatic logic signed [OUT_W-1:0] rs(input logic signed [IN_W-1:0] v);
    logic signed [IN_W:0] t;
    t = $signed({v[IN_W-1], v}) + HALF;
    t = t >>> SHIFT;
    if (t > MAX_V)
      rs = MAX_V[OUT_W-1:0];
    else if (t < MIN_V)
      rs = MIN_V[OUT_W-1:0];
    else
      rs = t[OUT_W-1:0];
  endfunction

  assign y = rs(x);

endmodule

// File: rtl/polyphase_output_commutator.sv
// Captures the four branch outputs per low-rate period and serialises them in
// phase order at the high rate through round/saturate rescaling.
module polyphase_output_commutator
  import polyphase_commutator_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  polyphase_output_commutator_if.slave  bus
);

  logic signed [IN_W-1:0]  bank_p0 [PHASES];
  phase_t                  sel_p0;
  logic                    busy_p0;
  logic signed [OUT_W-1:0] rs_y;

  logic signed [OUT_W-1:0] data_p1;
  phase_t                  phase_p1;
  logic                    vld_p1;
  logic                    overrun_q;

  round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .x (bank_p0[sel_p0]),
    .y (rs_y)
  );

  // p0 -> p1: emit the selected bank entry, then let a new capture override
  // sel/busy on the same edge so the old entry leaves before it is replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_p0   <= '{default: '0};
      sel_p0    <= '0;
      busy_p0   <= 1'b0;
      data_p1   <= '0;
      phase_p1  <= '0;
      vld_p1    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (busy_p0) begin
        data_p1  <= rs_y;
        phase_p1 <= sel_p0;
        vld_p1   <= 1'b1;
        if (sel_p0 == LAST_PHASE)
          busy_p0 <= 1'b0;
        else
          sel_p0 <= sel_p0 + 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end

      if (bus.in_valid) begin
        bank_p0[0] <= bus.in_e0;
        bank_p0[1] <= bus.in_e1;
        bank_p0[2] <= bus.in_e2;
        bank_p0[3] <= bus.in_e3;
        sel_p0     <= '0;
        busy_p0    <= 1'b1;
        if (busy_p0 && (sel_p0 != LAST_PHASE))
          overrun_q <= 1'b1;
      end
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_phase = phase_p1;
  assign bus.out_valid = vld_p1;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_polyphase_output_commutator.sv
// Scoreboard bench for the polyphase output commutator.
module tb_polyphase_output_commutator;
  import polyphase_commutator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  polyphase_output_commutator_if bus ();

  polyphase_output_commutator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int phase;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errors  = 0;
  int   run     = 0;
  int   max_run = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int data, input int phase);
    exp_t e;
    e.data  = data;
    e.phase = phase;
    sbq.push_back(e);
  endtask

  task automatic step(input logic v, input int e0, input int e1,
                      input int e2, input int e3);
    bus.in_valid = v;
    bus.in_e0    = IN_W'(e0);
    bus.in_e1    = IN_W'(e1);
    bus.in_e2    = IN_W'(e2);
    bus.in_e3    = IN_W'(e3);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
      if (sbq.size() == 0) begin
        chk("spurious_valid", bus.out_valid, 0);
      end else begin
        e = sbq.pop_front();
        chk("out_data", $signed(bus.out_data), e.data);
        chk("out_phase", bus.out_phase, e.phase);
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_e0 = '0;
    bus.in_e1 = '0;
    bus.in_e2 = '0;
    bus.in_e3 = '0;

    // Reset held with in_valid asserted: nothing captured, outputs cleared.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 100000, 200000, 300000, 400000);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", $signed(bus.out_data), 0);
      chk("rst_phase", bus.out_phase, 0);
      chk("rst_overrun", bus.overrun, 0);
    end
    rst = 1'b0;
    idle(6);
    chk("rst_no_capture", bus.out_valid, 0);

    // Single set with rounding ties and near-ties.
    push(1, 0); push(0, 1); push(0, 2); push(-1, 3);
    step(1'b1, 256, 255, -256, -257);
    chk("lat_capture_edge", bus.out_valid, 0);
    idle(1);
    chk("lat_first_phase", bus.out_valid, 1);
    idle(6);
    chk("single_drain", sbq.size(), 0);
    chk("single_idle", bus.out_valid, 0);
    chk("single_run", max_run, 4);

    // Saturation at both rails.
    push(1023, 0); push(-1024, 1); push(1023, 2); push(-1023, 3);
    step(1'b1, 524287, -524288, 523776, -523777);
    idle(6);
    chk("sat_drain", sbq.size(), 0);

    // Continuous stream at the maximum sustained rate.
    max_run = 0;
    for (int k = 0; k < 10; k++) begin
      for (int p = 0; p < 4; p++) push(k * 4 + p, p);
      step(1'b1, (k * 4) * 512, (k * 4 + 1) * 512, (k * 4 + 2) * 512, (k * 4 + 3) * 512);
      idle(3);
    end
    idle(4);
    chk("stream_drain", sbq.size(), 0);
    chk("stream_run", max_run, 40);
    chk("stream_overrun", bus.overrun, 0);

    // Early strobe: set A truncated after phase 1, set B complete.
    push(5, 0); push(6, 1);
    push(-1, 0); push(-2, 1); push(-3, 2); push(-4, 3);
    step(1'b1, 5 * 512, 6 * 512, 7 * 512, 8 * 512);
    step(1'b0, 0, 0, 0, 0);
    chk("early_pre_overrun", bus.overrun, 0);
    step(1'b1, -512, -1024, -1536, -2048);
    chk("early_overrun_set", bus.overrun, 1);
    idle(6);
    chk("early_drain", sbq.size(), 0);
    chk("early_overrun_sticky", bus.overrun, 1);

    // Reset mid-set: phases 2 and 3 never appear.
    push(10, 0); push(11, 1);
    step(1'b1, 10 * 512, 11 * 512, 12 * 512, 13 * 512);
    idle(2);
    rst = 1'b1;
    step(1'b0, 0, 0, 0, 0);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_data", $signed(bus.out_data), 0);
    chk("midrst_phase", bus.out_phase, 0);
    chk("midrst_overrun", bus.overrun, 0);
    rst = 1'b0;
    idle(6);
    chk("midrst_drain", sbq.size(), 0);
    chk("midrst_idle", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
